// File: rtl/router_ovalid_skid_reg.sv
// Per-channel egress valid/data register; MODE=1 skid buffer, MODE=0 plain flop with overwrite flag.
// Latency: 1 cycle from accept to out_valid in both modes.
// Backpressure: MODE=1 registered in_ready (low only when skid full); MODE=0 ignores out_ready.
module router_ovalid_skid_reg #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 32,
  parameter bit MODE   = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic [NUM_CH-1:0]        in_valid,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  output logic [NUM_CH-1:0]        in_ready,
  output logic [NUM_CH-1:0]        out_valid,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  input  logic [NUM_CH-1:0]        out_ready,
  output logic [NUM_CH-1:0]        drop_err,
  output logic                     busy
);

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b11
  } slot_e;

  logic [NUM_CH-1:0] main_v;
  logic [NUM_CH-1:0] skid_v;

  assign busy = |{main_v, skid_v};

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [DATA_W-1:0] din;
    logic [DATA_W-1:0] main_d;
    logic              in_ready_q;
    logic              accept;

    assign din                           = in_data[c*DATA_W +: DATA_W];
    assign in_ready[c]                   = in_ready_q & ~flush;
    assign accept                        = in_valid[c] & in_ready[c];
    assign out_valid[c]                  = main_v[c];
    assign out_data[c*DATA_W +: DATA_W]  = main_d;

    if (MODE) begin : g_skid
      slot_e             st;
      slot_e             st_nxt;
      logic [DATA_W-1:0] skid_d;
      logic              ld_main_in;
      logic              ld_main_skid;
      logic              ld_skid;

      assign main_v[c]   = st[0];
      assign skid_v[c]   = st[1];
      assign drop_err[c] = 1'b0;

      always_comb begin
        st_nxt       = st;
        ld_main_in   = 1'b0;
        ld_main_skid = 1'b0;
        ld_skid      = 1'b0;
        case (st)
          EMPTY: if (accept) begin
            st_nxt     = ONE;
            ld_main_in = 1'b1;
          end
          ONE: begin
            if (accept && out_ready[c]) begin
              ld_main_in = 1'b1;
            end else if (accept) begin
              st_nxt  = FULL;
              ld_skid = 1'b1;
            end else if (out_ready[c]) begin
              st_nxt = EMPTY;
            end
          end
          FULL: if (out_ready[c]) begin
            st_nxt       = ONE;
            ld_main_skid = 1'b1;
          end
          default: st_nxt = EMPTY;
        endcase
        // Flush drops every held beat but leaves payload registers untouched.
        if (flush) begin
          st_nxt       = EMPTY;
          ld_main_in   = 1'b0;
          ld_main_skid = 1'b0;
          ld_skid      = 1'b0;
        end
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          st         <= EMPTY;
          in_ready_q <= 1'b0;
          main_d     <= '0;
          skid_d     <= '0;
        end else begin
          st         <= st_nxt;
          in_ready_q <= ~st_nxt[1];
          if (ld_main_in)   main_d <= din;
          if (ld_main_skid) main_d <= skid_d;
          if (ld_skid)      skid_d <= din;
        end
      end
    end else begin : g_plain
      logic vld_q;
      logic err_q;

      assign main_v[c]   = vld_q;
      assign skid_v[c]   = 1'b0;
      assign drop_err[c] = err_q;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          vld_q      <= 1'b0;
          err_q      <= 1'b0;
          in_ready_q <= 1'b0;
          main_d     <= '0;
        end else begin
          in_ready_q <= 1'b1;
          vld_q      <= accept;
          if (accept) main_d <= din;
          if (vld_q && !out_ready[c] && in_valid[c]) err_q <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_router_ovalid_skid_reg.sv
// Bench for router_ovalid_skid_reg: skid instance (MODE=1) and plain instance (MODE=0).
module tb_router_ovalid_skid_reg;
  localparam int NC = 4;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset;
  logic             flush;
  logic [NC-1:0]    in_valid, in_ready, out_valid, out_ready, drop_err;
  logic [NC*DW-1:0] in_data, out_data;
  logic             busy;

  logic             flush_p;
  logic [NC-1:0]    in_valid_p, in_ready_p, out_valid_p, out_ready_p, drop_err_p;
  logic [NC*DW-1:0] in_data_p, out_data_p;
  logic             busy_p;

  router_ovalid_skid_reg #(.NUM_CH(NC), .DATA_W(DW), .MODE(1'b1)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .drop_err(drop_err), .busy(busy)
  );

  router_ovalid_skid_reg #(.NUM_CH(NC), .DATA_W(DW), .MODE(1'b0)) dut_p (
    .clk(clk), .reset(reset), .flush(flush_p),
    .in_valid(in_valid_p), .in_data(in_data_p), .in_ready(in_ready_p),
    .out_valid(out_valid_p), .out_data(out_data_p), .out_ready(out_ready_p),
    .drop_err(drop_err_p), .busy(busy_p)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    int          ch;
    logic        iv;
    logic [31:0] d;
    logic        ordy;
    logic        fl;
    logic        ov;
    logic [31:0] od;
    logic        ir;
    logic        bz;
  } vec_t;

  vec_t tbl[11];

  task automatic apply_vec(input vec_t v, input int idx);
    in_valid  = '0;
    in_data   = '0;
    out_ready = '1;
    flush     = v.fl;
    in_valid[v.ch]          = v.iv;
    in_data[v.ch*DW +: DW]  = v.d;
    out_ready[v.ch]         = v.ordy;
    @(posedge clk); #1;
    chk($sformatf("vec%0d out_valid", idx), 32'(out_valid[v.ch]), 32'(v.ov));
    chk($sformatf("vec%0d out_data", idx), out_data[v.ch*DW +: DW], v.od);
    chk($sformatf("vec%0d in_ready", idx), 32'(in_ready[v.ch]), 32'(v.ir));
    chk($sformatf("vec%0d busy", idx), 32'(busy), 32'(v.bz));
  endtask

  logic [31:0] q[NC][$];

  initial begin
    // ch1 stall into FULL and drain in order, then ch2 FULL followed by flush.
    tbl[0]  = '{1, 1'b1, 32'h10, 1'b1, 1'b0, 1'b1, 32'h10, 1'b1, 1'b1};
    tbl[1]  = '{1, 1'b1, 32'h11, 1'b1, 1'b0, 1'b1, 32'h11, 1'b1, 1'b1};
    tbl[2]  = '{1, 1'b1, 32'h22, 1'b0, 1'b0, 1'b1, 32'h11, 1'b0, 1'b1};
    tbl[3]  = '{1, 1'b1, 32'h33, 1'b0, 1'b0, 1'b1, 32'h11, 1'b0, 1'b1};
    tbl[4]  = '{1, 1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 32'h22, 1'b1, 1'b1};
    tbl[5]  = '{1, 1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 32'h22, 1'b1, 1'b0};
    tbl[6]  = '{2, 1'b1, 32'hA1, 1'b0, 1'b0, 1'b1, 32'hA1, 1'b1, 1'b1};
    tbl[7]  = '{2, 1'b1, 32'hA2, 1'b0, 1'b0, 1'b1, 32'hA1, 1'b0, 1'b1};
    tbl[8]  = '{2, 1'b1, 32'hA3, 1'b0, 1'b1, 1'b0, 32'hA1, 1'b0, 1'b0};
    tbl[9]  = '{2, 1'b1, 32'hA4, 1'b0, 1'b0, 1'b1, 32'hA4, 1'b1, 1'b1};
    tbl[10] = '{2, 1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 32'hA4, 1'b1, 1'b0};

    reset = 1'b0; flush = 1'b0; in_valid = '0; in_data = '0; out_ready = '1;
    flush_p = 1'b0; in_valid_p = '0; in_data_p = '0; out_ready_p = '0;

    // reset state
    #12;
    chk("rst out_valid", 32'(out_valid), 32'h0);
    chk("rst in_ready", 32'(in_ready), 32'h0);
    chk("rst busy", 32'(busy), 32'h0);
    chk("rst drop_err_p", 32'(drop_err_p), 32'h0);
    chk("rst in_ready_p", 32'(in_ready_p), 32'h0);
    @(posedge clk); #1;
    chk("rst held in_ready", 32'(in_ready), 32'h0);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("post-rst in_ready", 32'(in_ready), 32'hF);
    chk("post-rst in_ready_p", 32'(in_ready_p), 32'hF);

    // streaming: 8 beats on ch0, one per cycle, 1-cycle latency
    for (int k = 0; k < 8; k++) begin
      in_valid = 4'b0001;
      in_data  = '0;
      in_data[31:0] = 32'hA5A5_0001 + 32'(k);
      @(posedge clk); #1;
      chk($sformatf("stream%0d out_valid", k), 32'(out_valid[0]), 32'h1);
      chk($sformatf("stream%0d out_data", k), out_data[31:0], 32'hA5A5_0001 + 32'(k));
    end
    in_valid = '0;
    @(posedge clk); #1;
    chk("stream end out_valid", 32'(out_valid[0]), 32'h0);

    for (int i = 0; i < 11; i++) apply_vec(tbl[i], i);
    flush = 1'b0; in_valid = '0; out_ready = '1;

    // plain mode overwrite on ch3
    in_valid_p = 4'b1000; in_data_p = '0; in_data_p[3*DW +: DW] = 32'h5;
    @(posedge clk); #1;
    chk("plain beat1 out_valid", 32'(out_valid_p[3]), 32'h1);
    chk("plain beat1 out_data", out_data_p[3*DW +: DW], 32'h5);
    chk("plain beat1 drop_err", 32'(drop_err_p), 32'h0);
    in_data_p[3*DW +: DW] = 32'h6;
    @(posedge clk); #1;
    chk("plain beat2 out_data", out_data_p[3*DW +: DW], 32'h6);
    chk("plain beat2 drop_err", 32'(drop_err_p), 32'h8);
    in_valid_p = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("plain sticky drop_err", 32'(drop_err_p), 32'h8);
    chk("plain idle out_valid", 32'(out_valid_p), 32'h0);

    // async reset with ch0 FULL
    out_ready = 4'b1110; in_valid = 4'b0001; in_data = '0; in_data[31:0] = 32'hB1;
    @(posedge clk); #1;
    in_data[31:0] = 32'hB2;
    @(posedge clk); #1;
    chk("full ch0 in_ready", 32'(in_ready[0]), 32'h0);
    chk("full ch0 out_data", out_data[31:0], 32'hB1);
    in_valid = '0;
    #2 reset = 1'b0;
    #1;
    chk("async rst out_valid", 32'(out_valid), 32'h0);
    chk("async rst busy", 32'(busy), 32'h0);
    chk("async rst in_ready", 32'(in_ready), 32'h0);
    chk("async rst drop_err_p", 32'(drop_err_p), 32'h0);
    @(posedge clk); #1;
    chk("rst held2 in_ready", 32'(in_ready), 32'h0);
    reset = 1'b1; out_ready = '1;
    @(posedge clk); #1;
    chk("rerelease in_ready", 32'(in_ready), 32'hF);
    chk("rerelease out_valid", 32'(out_valid), 32'h0);
    @(posedge clk); #1;
    chk("no stale beat", 32'(out_valid), 32'h0);
    chk("no stale busy", 32'(busy), 32'h0);

    // random traffic against a 2-deep per-channel queue model
    for (int cyc = 0; cyc < 10000; cyc++) begin
      bit drain;
      drain = (cyc >= 9980);
      for (int c = 0; c < NC; c++) begin
        in_valid[c]          = drain ? 1'b0 : ($urandom_range(0, 99) < 60);
        in_data[c*DW +: DW]  = $urandom;
        out_ready[c]         = drain ? 1'b1 : ($urandom_range(0, 99) < 30 + 15 * c);
      end
      #4;
      for (int c = 0; c < NC; c++) begin
        logic exp_ov, exp_ir, acc, pres;
        exp_ov = (q[c].size() != 0);
        exp_ir = (q[c].size() < 2);
        chk($sformatf("rnd c%0d cyc%0d out_valid", c, cyc), 32'(out_valid[c]), 32'(exp_ov));
        if (exp_ov)
          chk($sformatf("rnd c%0d cyc%0d out_data", c, cyc), out_data[c*DW +: DW], q[c][0]);
        chk($sformatf("rnd c%0d cyc%0d in_ready", c, cyc), 32'(in_ready[c]), 32'(exp_ir));
        acc  = in_valid[c] & exp_ir;
        pres = exp_ov & out_ready[c];
        if (pres) void'(q[c].pop_front());
        if (acc) q[c].push_back(in_data[c*DW +: DW]);
      end
      @(posedge clk); #1;
    end
    chk("drain out_valid", 32'(out_valid), 32'h0);
    chk("drain busy", 32'(busy), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
